// File: rtl/common_ram_arbiter_if.sv
// Shared-RAM arbiter bus bundle.
// Carries the requester side (request/direction/address/write data in,
// completion pulse/error/read data/grant out) and the RAM side (separate
// read and write valid/ready ports).
//   slave  : arbiter's view (takes requests, drives the RAM ports)
//   master : environment's view (requesters plus RAM)
// Requester i occupies slice [i*W +: W] of the packed address/data vectors.
interface common_ram_arbiter_if #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  localparam int G = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS-1:0]               req_vaild;
  logic [REQUESTERS-1:0]               req_write;
  logic [REQUESTERS*ADDRESS_WIDTH-1:0] req_address;
  logic [REQUESTERS*DATA_WIDTH-1:0]    req_write_data;
  logic [REQUESTERS-1:0]               req_ready;
  logic                                req_error;
  logic [DATA_WIDTH-1:0]               req_read_data;
  logic [G-1:0]                        grant_id;

  logic                     bus_read_vaild;
  logic                     bus_read_ready;
  logic [ADDRESS_WIDTH-1:0] bus_read_address;
  logic [DATA_WIDTH-1:0]    bus_read_data;
  logic                     bus_write_vaild;
  logic                     bus_write_ready;
  logic [ADDRESS_WIDTH-1:0] bus_write_address;
  logic [DATA_WIDTH-1:0]    bus_write_data;

  modport slave (
    input  req_vaild, req_write, req_address, req_write_data,
    output req_ready, req_error, req_read_data, grant_id,
    output bus_read_vaild, bus_read_address,
    input  bus_read_ready, bus_read_data,
    output bus_write_vaild, bus_write_address, bus_write_data,
    input  bus_write_ready
  );

  modport master (
    output req_vaild, req_write, req_address, req_write_data,
    input  req_ready, req_error, req_read_data, grant_id,
    input  bus_read_vaild, bus_read_address,
    output bus_read_ready, bus_read_data,
    input  bus_write_vaild, bus_write_address, bus_write_data,
    output bus_write_ready
  );
endinterface

// File: rtl/common_ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one RAM between REQUESTERS masters.
// One transaction in flight: IDLE picks a winner and latches it, BUSY drives
// the selected RAM port from registers until accept (or watchdog abort),
// DONE issues a one-cycle req_ready pulse (visible the cycle after DONE).
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - common_ram_arbiter_if.slave (requester and RAM signals)
module common_ram_arbiter #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 16
) (
  input logic                  clock,
  input logic                  reset,
  common_ram_arbiter_if.slave  bus
);
  localparam int G = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [G-1:0] LAST_RST = G'(REQUESTERS - 1);
  localparam logic [7:0]   WD_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;

  logic [G-1:0]             last_grant, pick;
  logic                     any_req, lat_write, err_flag, accept, abort;
  logic [7:0]               wdog;
  logic                     sel_write;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;

  // Priority starts just above last_grant: first scan the indices above it,
  // then wrap around to the ones at or below it.
  always_comb begin
    pick    = last_grant;
    any_req = 1'b0;
    for (int j = 0; j < REQUESTERS; j++)
      if (!any_req && bus.req_vaild[j] && j > int'(last_grant)) begin
        any_req = 1'b1;
        pick    = G'(j);
      end
    for (int j = 0; j < REQUESTERS; j++)
      if (!any_req && bus.req_vaild[j] && j <= int'(last_grant)) begin
        any_req = 1'b1;
        pick    = G'(j);
      end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int j = 0; j < REQUESTERS; j++)
      if (pick == G'(j)) begin
        sel_write = bus.req_write[j];
        sel_addr  = bus.req_address[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_data  = bus.req_write_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  // Only the latched direction's ready counts; the other port is ignored.
  assign accept = (state == BUSY) &&
                  (lat_write ? bus.bus_write_ready : bus.bus_read_ready);
  // Watchdog holds TIMEOUT on the last waiting cycle; abort on that edge.
  assign abort  = (state == BUSY) && !accept && (wdog == WD_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = BUSY;
      BUSY:    if (accept || abort) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.req_ready         <= '0;
      bus.req_error         <= 1'b0;
      bus.req_read_data     <= '0;
      bus.grant_id          <= '0;
      bus.bus_read_vaild    <= 1'b0;
      bus.bus_read_address  <= '0;
      bus.bus_write_vaild   <= 1'b0;
      bus.bus_write_address <= '0;
      bus.bus_write_data    <= '0;
      last_grant            <= LAST_RST;
      lat_write             <= 1'b0;
      err_flag              <= 1'b0;
      wdog                  <= '0;
    end else begin
      bus.req_ready <= '0;
      bus.req_error <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          bus.grant_id <= pick;
          lat_write    <= sel_write;
          wdog         <= '0;
          // Only the selected port's registers load; the other port holds.
          if (sel_write) begin
            bus.bus_write_vaild   <= 1'b1;
            bus.bus_write_address <= sel_addr;
            bus.bus_write_data    <= sel_data;
          end else begin
            bus.bus_read_vaild    <= 1'b1;
            bus.bus_read_address  <= sel_addr;
          end
        end
        BUSY: begin
          if (accept) begin
            bus.bus_read_vaild  <= 1'b0;
            bus.bus_write_vaild <= 1'b0;
            if (!lat_write) bus.req_read_data <= bus.bus_read_data;
          end else if (abort) begin
            bus.bus_read_vaild  <= 1'b0;
            bus.bus_write_vaild <= 1'b0;
            bus.req_read_data   <= '0;
            err_flag            <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        DONE: begin
          for (int j = 0; j < REQUESTERS; j++)
            if (bus.grant_id == G'(j)) bus.req_ready[j] <= 1'b1;
          bus.req_error <= err_flag;
          err_flag      <= 1'b0;
          last_grant    <= bus.grant_id;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_common_ram_arbiter.sv
// Self-checking bench for common_ram_arbiter: a RAM responder with random
// accept delay, a bus monitor, and one task per scenario.
module tb_common_ram_arbiter;
  localparam int N = 2, AW = 5, DW = 32, TO = 16, G = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  common_ram_arbiter_if #(.REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  common_ram_arbiter #(.REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO))
    dut (.clock(clk), .reset(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // RAM contents as seen by the RAM, and the expected contents by completion order.
  logic [DW-1:0] mem     [32];
  logic [DW-1:0] ref_mem [32];

  // RAM responder: accept after dlo..dhi cycles of valid, never when stalled,
  // random ready on the idle port when noise is set.
  int dcnt = 0, dlo = 0, dhi = 0;
  bit go = 0, stall = 0, noise = 0;
  always @(negedge clk) begin
    if (!bus.bus_read_vaild && !bus.bus_write_vaild) begin
      dcnt = $urandom_range(dhi, dlo);
      go   = 0;
    end else if (!stall && !go) begin
      if (dcnt == 0) go = 1;
      else dcnt--;
    end
    bus.bus_read_ready  = bus.bus_read_vaild  ? go : (noise ? 1'($urandom % 2) : 1'b0);
    bus.bus_write_ready = bus.bus_write_vaild ? go : (noise ? 1'($urandom % 2) : 1'b0);
    bus.bus_read_data   = bus.bus_read_vaild ? mem[bus.bus_read_address] : $urandom;
  end

  // Monitor: RAM accepts, port overlap, output stability while valid, pulses.
  typedef struct { bit wr; logic [AW-1:0] a; logic [DW-1:0] d; } acc_t;
  acc_t acc_q[$];
  int cyc = 0, rvld_cycles = 0, overlap_cnt = 0, unstable_cnt = 0;
  int multi_cnt = 0, onehot_bad = 0, ready_pulses = 0;
  bit prv = 0, pwv = 0;
  logic [AW-1:0] pra = '0, pwa = '0;
  logic [DW-1:0] pwd = '0;
  logic [N-1:0]  prev_rdy = '0;
  always @(posedge clk) begin
    cyc++;
    if (bus.bus_read_vaild === 1'b1) begin
      rvld_cycles++;
      if (prv && bus.bus_read_address !== pra) unstable_cnt++;
    end
    if (bus.bus_write_vaild === 1'b1)
      if (pwv && (bus.bus_write_address !== pwa || bus.bus_write_data !== pwd)) unstable_cnt++;
    prv = (bus.bus_read_vaild === 1'b1);
    pwv = (bus.bus_write_vaild === 1'b1);
    pra = bus.bus_read_address;
    pwa = bus.bus_write_address;
    pwd = bus.bus_write_data;
    if (bus.bus_read_vaild === 1'b1 && bus.bus_write_vaild === 1'b1) overlap_cnt++;
    if (bus.bus_read_vaild === 1'b1 && bus.bus_read_ready === 1'b1)
      acc_q.push_back('{1'b0, bus.bus_read_address, bus.bus_read_data});
    if (bus.bus_write_vaild === 1'b1 && bus.bus_write_ready === 1'b1) begin
      acc_q.push_back('{1'b1, bus.bus_write_address, bus.bus_write_data});
      mem[bus.bus_write_address] = bus.bus_write_data;
    end
    if (bus.req_ready !== '0) begin
      ready_pulses++;
      if (!$onehot(bus.req_ready)) onehot_bad++;
      if (prev_rdy !== '0) multi_cnt++;
    end
    prev_rdy = bus.req_ready;
  end

  task automatic issue(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_vaild[id] = 1'b1;
    bus.req_write[id] = wr;
    bus.req_address[id*AW +: AW]    = a;
    bus.req_write_data[id*DW +: DW] = d;
  endtask

  // Waits (bounded) for requester id's completion, then drops its request.
  task automatic wait_ready(input int id, input int budget, output bit ok, output int seen,
                            output logic [N-1:0] rv, output logic [DW-1:0] rd,
                            output logic er, output logic [G-1:0] g);
    ok = 0; seen = 0; rv = '0; rd = '0; er = 1'b0; g = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.req_ready[id] === 1'b1) begin
        ok = 1; seen = cyc; rv = bus.req_ready; rd = bus.req_read_data;
        er = bus.req_error; g = bus.grant_id;
        bus.req_vaild[id] = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok; int sc; logic [N-1:0] rv; logic [DW-1:0] rd; logic er; logic [G-1:0] g;
    rst = 1'b1;
    bus.req_vaild      = N'($urandom);
    bus.req_write      = N'($urandom);
    bus.req_address    = (N*AW)'($urandom);
    bus.req_write_data = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%0h exp=0", bus.req_ready); end
    checks++; if (bus.req_error !== 1'b0) begin errors++; $display("FAIL reset_req_error got=%0h exp=0", bus.req_error); end
    checks++; if (bus.req_read_data !== '0) begin errors++; $display("FAIL reset_read_data got=%0h exp=0", bus.req_read_data); end
    checks++; if (bus.grant_id !== '0) begin errors++; $display("FAIL reset_grant_id got=%0h exp=0", bus.grant_id); end
    checks++; if ({bus.bus_read_vaild, bus.bus_write_vaild} !== 2'b00) begin errors++; $display("FAIL reset_valids got=%b exp=00", {bus.bus_read_vaild, bus.bus_write_vaild}); end
    checks++; if ({bus.bus_read_address, bus.bus_write_address, bus.bus_write_data} !== '0) begin errors++; $display("FAIL reset_bus_regs got=%0h exp=0", {bus.bus_read_address, bus.bus_write_address, bus.bus_write_data}); end
    bus.req_vaild = '0;
    rst = 1'b0;
    issue(0, 0, 5'd1, '0);
    issue(1, 0, 5'd2, '0);
    @(negedge clk);
    checks++; if (bus.grant_id !== 1'b0) begin errors++; $display("FAIL reset_first_grant got=%0h exp=0", bus.grant_id); end
    wait_ready(0, 20, ok, sc, rv, rd, er, g);
    checks++; if (!ok) begin errors++; $display("FAIL reset_req0_done got=none exp=ready"); end
    wait_ready(1, 20, ok, sc, rv, rd, er, g);
    checks++; if (!ok || g !== 1'b1) begin errors++; $display("FAIL reset_req1_done got=ok%0d/g%0d exp=ok1/g1", ok, g); end
  endtask

  task automatic test_single_read();
    bit ok; int sc, c; logic [N-1:0] rv; logic [DW-1:0] rd; logic er; logic [G-1:0] g;
    dlo = 1; dhi = 1;
    @(negedge clk);
    rvld_cycles = 0;
    c = cyc;
    issue(0, 0, 5'd0, '0);
    wait_ready(0, 30, ok, sc, rv, rd, er, g);
    checks++; if (!ok) begin errors++; $display("FAIL single_done got=none exp=ready"); end
    checks++; if (rvld_cycles != 2) begin errors++; $display("FAIL single_rvalid_cycles got=%0d exp=2", rvld_cycles); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL single_ready_vec got=%b exp=01", rv); end
    checks++; if (er !== 1'b0 || rd !== ref_mem[0]) begin errors++; $display("FAIL single_data got=err%0d/%0h exp=err0/%0h", er, rd, ref_mem[0]); end
    checks++; if (sc - c - 1 != 3) begin errors++; $display("FAIL single_latency got=%0d exp=3", sc - c - 1); end
    @(negedge clk);
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL single_pulse_len got=%b exp=00", bus.req_ready); end
    dlo = 0; dhi = 0;
  endtask

  task automatic test_write_read();
    bit ok; int sc; logic [N-1:0] rv; logic [DW-1:0] rd; logic er; logic [G-1:0] g;
    acc_q.delete();
    issue(1, 1, 5'd0, 32'h0000_0001);
    wait_ready(1, 30, ok, sc, rv, rd, er, g);
    checks++; if (!ok || er !== 1'b0 || g !== 1'b1) begin errors++; $display("FAIL wr_done got=ok%0d/err%0d/g%0d exp=ok1/err0/g1", ok, er, g); end
    checks++; if (acc_q.size() != 1 || !acc_q[0].wr || acc_q[0].a !== 5'd0 || acc_q[0].d !== 32'h1)
      begin errors++; $display("FAIL wr_port got=n%0d exp=one write a0 d1", acc_q.size()); end
    if (ok) ref_mem[0] = 32'h0000_0001;
    issue(1, 0, 5'd0, '0);
    wait_ready(1, 30, ok, sc, rv, rd, er, g);
    checks++; if (!ok || rd !== ref_mem[0]) begin errors++; $display("FAIL wr_readback got=%0h exp=%0h", rd, ref_mem[0]); end
  endtask

  task automatic test_contention();
    int gseq[$]; int n;
    acc_q.delete();
    issue(0, 0, 5'd3, '0);
    issue(1, 0, 5'd7, '0);
    n = 0;
    for (int i = 0; i < 100 && gseq.size() < 4; i++) begin
      @(negedge clk);
      if (bus.req_ready !== '0) gseq.push_back(int'(bus.grant_id));
    end
    bus.req_vaild = '0;
    checks++; if (gseq.size() != 4) begin errors++; $display("FAIL cont_count got=%0d exp=4", gseq.size()); end
    foreach (gseq[j]) begin
      checks++; if (gseq[j] != j % N) begin errors++; $display("FAIL cont_grant[%0d] got=%0d exp=%0d", j, gseq[j], j % N); end
    end
    foreach (acc_q[j]) n++;
    checks++; if (n != 4) begin errors++; $display("FAIL cont_ram_count got=%0d exp=4", n); end
    foreach (acc_q[j]) begin
      checks++; if (acc_q[j].a !== ((j % 2) ? 5'd7 : 5'd3) || acc_q[j].wr)
        begin errors++; $display("FAIL cont_addr[%0d] got=%0d exp=%0d", j, acc_q[j].a, (j % 2) ? 7 : 3); end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok; int sc, c; logic [N-1:0] rv; logic [DW-1:0] rd; logic er; logic [G-1:0] g;
    issue(0, 0, 5'd0, '0);
    wait_ready(0, 30, ok, sc, rv, rd, er, g);
    stall = 1;
    c = cyc;
    issue(0, 0, 5'd5, '0);
    wait_ready(0, 60, ok, sc, rv, rd, er, g);
    checks++; if (!ok) begin errors++; $display("FAIL to_done got=none exp=ready"); end
    checks++; if (sc - c - 1 != TO + 2) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", sc - c - 1, TO + 2); end
    checks++; if (er !== 1'b1 || rv !== 2'b01) begin errors++; $display("FAIL to_error got=err%0d/%b exp=err1/01", er, rv); end
    checks++; if (rd !== '0) begin errors++; $display("FAIL to_read_data got=%0h exp=0", rd); end
    stall = 0;
    c = cyc;
    issue(0, 0, 5'd0, '0);
    wait_ready(0, 30, ok, sc, rv, rd, er, g);
    checks++; if (!ok || er !== 1'b0 || rd !== ref_mem[0] || sc - c - 1 != 2)
      begin errors++; $display("FAIL to_recover got=ok%0d/err%0d/%0h/lat%0d exp=ok1/err0/%0h/lat2", ok, er, rd, sc - c - 1, ref_mem[0]); end
  endtask

  task automatic test_reset_mid_busy();
    bit ok; int sc, p0; logic [N-1:0] rv; logic [DW-1:0] rd; logic er; logic [G-1:0] g;
    logic [DW-1:0] wd;
    stall = 1;
    issue(1, 1, 5'd9, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    checks++; if (bus.bus_write_vaild !== 1'b1) begin errors++; $display("FAIL rmb_pending got=%0b exp=1", bus.bus_write_vaild); end
    p0 = ready_pulses;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.bus_write_vaild !== 1'b0 || bus.bus_read_vaild !== 1'b0)
      begin errors++; $display("FAIL rmb_async_drop got=w%0b/r%0b exp=0/0", bus.bus_write_vaild, bus.bus_read_vaild); end
    bus.req_vaild = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stall = 0;
    checks++; if (ready_pulses != p0) begin errors++; $display("FAIL rmb_no_ready got=%0d exp=%0d", ready_pulses, p0); end
    wd = $urandom;
    acc_q.delete();
    issue(1, 1, 5'd9, wd);
    issue(0, 0, 5'd0, '0);
    @(negedge clk);
    checks++; if (bus.grant_id !== 1'b0) begin errors++; $display("FAIL rmb_first_grant got=%0d exp=0", bus.grant_id); end
    wait_ready(0, 30, ok, sc, rv, rd, er, g);
    checks++; if (!ok || rd !== ref_mem[0]) begin errors++; $display("FAIL rmb_req0 got=ok%0d/%0h exp=ok1/%0h", ok, rd, ref_mem[0]); end
    wait_ready(1, 30, ok, sc, rv, rd, er, g);
    checks++; if (!ok || g !== 1'b1 || acc_q.size() != 2 || acc_q[1].a !== 5'd9 || acc_q[1].d !== wd)
      begin errors++; $display("FAIL rmb_req1 got=ok%0d/g%0d/n%0d exp=ok1/g1/n2 write a9 d%0h", ok, g, acc_q.size(), wd); end
    if (ok) ref_mem[9] = wd;
  endtask

  task automatic test_random();
    bit busy[N]; bit pwr[N]; logic [AW-1:0] pa[N]; logic [DW-1:0] pd[N]; int waited[N];
    int issued = 0, done = 0;
    localparam int TARGET = 200;
    dlo = 0; dhi = 3; noise = 1;
    for (int i = 0; i < N; i++) begin busy[i] = 0; waited[i] = 0; end
    for (int t = 0; t < 5000 && done < TARGET; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i] === 1'b1) begin
          checks++;
          if (!busy[i]) begin errors++; $display("FAIL rnd_spurious req%0d got=ready exp=idle", i); end
          else begin
            if (bus.grant_id !== G'(i) || bus.req_error !== 1'b0) begin
              errors++; $display("FAIL rnd_grant req%0d got=g%0d/err%0d exp=g%0d/err0", i, bus.grant_id, bus.req_error, i);
            end else if (!pwr[i] && bus.req_read_data !== ref_mem[pa[i]]) begin
              errors++; $display("FAIL rnd_read req%0d a%0d got=%0h exp=%0h", i, pa[i], bus.req_read_data, ref_mem[pa[i]]);
            end else if (waited[i] > N - 1) begin
              errors++; $display("FAIL rnd_fair req%0d got=%0d exp<=%0d", i, waited[i], N - 1);
            end
            if (pwr[i]) ref_mem[pa[i]] = pd[i];
            for (int j = 0; j < N; j++) if (j != i && busy[j]) waited[j]++;
            busy[i] = 0;
            bus.req_vaild[i] = 1'b0;
            done++;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!busy[i] && issued < TARGET && ($urandom % 3) == 0) begin
          pwr[i] = 1'($urandom % 2);
          pa[i]  = AW'($urandom_range(0, 7));
          pd[i]  = $urandom;
          waited[i] = 0;
          busy[i] = 1;
          issued++;
          issue(i, pwr[i], pa[i], pd[i]);
        end
      end
    end
    bus.req_vaild = '0;
    noise = 0;
    checks++; if (done != TARGET) begin errors++; $display("FAIL rnd_completed got=%0d exp=%0d", done, TARGET); end
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL port_overlap got=%0d exp=0", overlap_cnt); end
    checks++; if (unstable_cnt != 0) begin errors++; $display("FAIL bus_stability got=%0d exp=0", unstable_cnt); end
    checks++; if (multi_cnt != 0 || onehot_bad != 0) begin errors++; $display("FAIL ready_pulse_shape got=multi%0d/onehot%0d exp=0/0", multi_cnt, onehot_bad); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    bus.req_vaild = '0;
    bus.req_write = '0;
    bus.req_address = '0;
    bus.req_write_data = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/common_ram_arbiter.md
# common_ram_arbiter

Round-robin arbiter and sequencer that shares one `common_ram` instance between up to four requesters. It sits between the core-side masters (prefetch, execute, descriptor loads) and the RAM's separate read and write valid/ready ports. Each requester issues one read or write at a time. The arbiter latches the request, drives exactly one RAM port until that port accepts, and returns a one-cycle completion pulse with read data. A watchdog aborts any transaction the RAM never accepts.

## Interface
Parameters:
- `REQUESTERS`, 2 — number of requesters; legal range 2..4
- `ADDRESS_WIDTH`, 5 — RAM word address width
- `DATA_WIDTH`, 32 — RAM data width
- `TIMEOUT`, 16 — maximum cycles in BUSY before abort; legal range 2..255

Ports (N = `REQUESTERS`, G = `$clog2(N)`):
- `clock`  in  1  — single clock; all state updates on its rising edge
- `reset`  in  1  — asynchronous, active-high reset
- `req_vaild`  in  N  — per-requester request; held high until `req_ready`
- `req_write`  in  N  — per-requester direction; 1 = write, 0 = read
- `req_address`  in  N*ADDRESS_WIDTH  — packed addresses; requester i occupies slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- `req_write_data`  in  N*DATA_WIDTH  — packed write data, sliced the same way
- `req_ready`  out  N  — one-cycle completion pulse, one-hot
- `req_error`  out  1  — high with `req_ready` when the transaction timed out
- `req_read_data`  out  DATA_WIDTH  — read data; valid in the `req_ready` cycle
- `grant_id`  out  G  — index of the current or last granted requester
- `bus_read_vaild`  out  1  — RAM read request
- `bus_read_ready`  in  1  — RAM read accept / data valid
- `bus_read_address`  out  ADDRESS_WIDTH  — RAM read address
- `bus_read_data`  in  DATA_WIDTH  — RAM read data
- `bus_write_vaild`  out  1  — RAM write request
- `bus_write_ready`  in  1  — RAM write accept
- `bus_write_address`  out  ADDRESS_WIDTH  — RAM write address
- `bus_write_data`  out  DATA_WIDTH  — RAM write data

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE:**
  - When any `req_vaild` bit is high, pick the first set bit, searching upward from `last_grant+1` and wrapping modulo N.
  - Latch the winner's index, `req_write`, address and write data.
  - Load the watchdog with 0 and go to BUSY.
  - Requesters not selected wait; their requests are never dropped.
- **BUSY:**
  - Drive the RAM port selected by the latched direction, from registers only.
  - For a read, `bus_read_vaild` = 1 and `bus_write_vaild` = 0; for a write, the reverse.
  - The unused port's valid is 0 and its address and data outputs hold their previous values.
  - Accept occurs on a rising edge where the selected port's ready = 1.
    - For a read, capture `bus_read_data` into `req_read_data`.
    - Then go to DONE.
  - The watchdog increments every BUSY cycle without accept.
    - When it reaches `TIMEOUT` with no accept, set the error flag and go to DONE.
    - On abort, `req_read_data` is set to 0.
- **DONE (one cycle):**
  - `req_ready[grant]` = 1 and `req_error` = error flag.
  - Deassert both RAM valids.
  - Set `last_grant` = grant, clear the error flag, return to IDLE.
- Ready on the non-selected RAM port is ignored.
- If a requester drops `req_vaild` while granted, the latched transaction still completes and still pulses `req_ready`.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0. No requester waits more than N-1 transactions.

## Timing
- Reset values:
  - all outputs 0: valids, `req_ready`, `req_error`, `req_read_data`, RAM addresses and data
  - `grant_id` = 0
  - state = IDLE
  - `last_grant` = N-1, so requester 0 wins first
- Reset asserted mid-transaction returns to IDLE immediately (asynchronously). The RAM valid drops within the reset cycle and no `req_ready` is issued.
- Latency: request sampled in IDLE at edge t gives RAM valid high from edge t+1.
  - RAM ready seen at edge t+1+k (k ≥ 0) gives `req_ready` high for the cycle after edge t+2+k.
  - Minimum request-to-ready latency is 3 edges.
- Throughput: one transaction per 3 cycles maximum, since IDLE and DONE are single cycles.
- Timeout: with ready held low, `req_ready` plus `req_error` occur exactly `TIMEOUT`+2 edges after the IDLE sample.
- RAM outputs are stable for the whole BUSY interval and never change while valid is high.
- `req_ready` is never high for more than one consecutive cycle per transaction.
- `grant_id` updates at the IDLE→BUSY edge and holds through DONE.

## Test plan
- **Reset:** assert `reset` for 2 cycles with random inputs -> every output 0; first grant after release goes to requester 0.
- **Single read:** req0 reads address 0, RAM returns 0x0000_0000 with ready one cycle after valid -> `bus_read_vaild` high 2 cycles; `req_ready` = 0b01 one cycle; `req_error` = 0; `req_read_data` = 0.
- **Write then read:** req1 writes 0x0000_0001 to address 0, then req1 reads address 0 -> write port carries addr 0, data 1; the read returns 0x0000_0001.
- **Contention:** req0 and req1 both hold reads to addresses 3 and 7 for 4 transactions -> `grant_id` sequence 0,1,0,1; the RAM sees addresses 3,7,3,7; no valid overlap between ports.
- **Timeout:** req0 reads with `bus_read_ready` held 0, `TIMEOUT` = 16 -> `req_ready[0]` and `req_error` high together 18 edges after the request sample; `req_read_data` = 0; the next request proceeds normally.
- **Reset mid-BUSY:** assert `reset` while a write is pending with ready low -> `bus_write_vaild` drops immediately; no `req_ready` pulse; after release, a new req1 request is served first from `last_grant` = N-1 order (req0 if also requesting).
